// File: rtl/clock_controller.sv
// Clock-controller front end: synchronises and debounces buttons, runs the mode/position FSM and emits counter-advance pulses.
// Optional alarm support is enabled by defining CLKCTRL_ALARM_EN; otherwise the mode cycles CLOCK<->SETUP only.
module clock_controller #(
  parameter int CLK_HZ     = 50000000,
  parameter int DEB_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_sw_mode,
  input  logic       i_sw_pos,
  input  logic       i_sw_inc,
  input  logic       i_sw_alarm,
  input  logic       i_max_hit_sec,
  input  logic       i_max_hit_min,
  output logic [1:0] o_mode,
  output logic [1:0] o_position,
  output logic       o_sec_clk,
  output logic       o_min_clk,
  output logic       o_hour_clk,
  output logic       o_alarm_sec_clk,
  output logic       o_alarm_min_clk,
  output logic       o_alarm_hour_clk,
  output logic       o_alarm_en
);

  localparam int TW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(CLK_HZ - 1);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_CYCLES - 1);

  localparam logic [1:0] POS_SEC  = 2'd0;
  localparam logic [1:0] POS_MIN  = 2'd1;
  localparam logic [1:0] POS_HOUR = 2'd2;

  typedef enum logic [1:0] {
    MODE_CLOCK = 2'd0,
    MODE_SETUP = 2'd1,
    MODE_ALARM = 2'd2
  } mode_e;

  // Button bit order: 0 = mode, 1 = position, 2 = inc, 3 = alarm.
  logic          alarm_raw;
  logic [3:0]    btn_raw;
  logic [3:0]    bs1_q, bs2_q, deb_q, deb_prev_q;
  logic [CW-1:0] cnt_q [4];
  logic [1:0]    cs1_q, cs2_q, cprev_q;
  logic [TW-1:0] tick_cnt_q;

  mode_e      mode_q, mode_d;
  logic [1:0] pos_q;
  logic       sec_q, min_q, hour_q, asec_q, amin_q, ahour_q, alarm_en_q;

`ifdef CLKCTRL_ALARM_EN
  assign alarm_raw = i_sw_alarm;
`else
  assign alarm_raw = 1'b0;
`endif

  assign btn_raw = {alarm_raw, i_sw_inc, i_sw_pos, i_sw_mode};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bs1_q      <= '0;
      bs2_q      <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      cs1_q      <= '0;
      cs2_q      <= '0;
      cprev_q    <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      bs1_q      <= btn_raw;
      bs2_q      <= bs1_q;
      deb_prev_q <= deb_q;
      cs1_q      <= {i_max_hit_min, i_max_hit_sec};
      cs2_q      <= cs1_q;
      cprev_q    <= cs2_q;
      // A level is accepted only after DEB_CYCLES samples differing from the current debounced value.
      for (int i = 0; i < 4; i++) begin
        if (bs2_q[i] == deb_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == DEB_LAST) begin
          deb_q[i] <= bs2_q[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tick_cnt_q <= '0;
    else if (tick_cnt_q == TICK_LAST) tick_cnt_q <= '0;
    else tick_cnt_q <= tick_cnt_q + TW'(1);
  end

  logic       tick, in_setup, in_alarm;
  logic [3:0] press;
  logic [1:0] carry;

  assign tick     = (tick_cnt_q == TICK_LAST);
  assign press    = deb_q & ~deb_prev_q;
  assign carry    = cs2_q & ~cprev_q;
  assign in_setup = (mode_q == MODE_SETUP);
  assign in_alarm = (mode_q == MODE_ALARM);

  always_comb begin
    mode_d = MODE_CLOCK;
    case (mode_q)
      MODE_CLOCK: mode_d = MODE_SETUP;
`ifdef CLKCTRL_ALARM_EN
      MODE_SETUP: mode_d = MODE_ALARM;
`else
      MODE_SETUP: mode_d = MODE_CLOCK;
`endif
      MODE_ALARM: mode_d = MODE_CLOCK;
      default:    mode_d = MODE_SETUP;
    endcase
  end

  // Pulse decisions use the mode in force when the event arrives; mode presses beat position presses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q     <= MODE_CLOCK;
      pos_q      <= POS_SEC;
      sec_q      <= 1'b0;
      min_q      <= 1'b0;
      hour_q     <= 1'b0;
      asec_q     <= 1'b0;
      amin_q     <= 1'b0;
      ahour_q    <= 1'b0;
      alarm_en_q <= 1'b0;
    end else begin
      if (press[0]) begin
        mode_q <= mode_d;
        pos_q  <= POS_SEC;
      end else if (press[1]) begin
        pos_q <= (pos_q == POS_HOUR) ? POS_SEC : pos_q + 2'd1;
      end
      sec_q   <= (!in_setup && tick)     || (in_setup && press[2] && pos_q == POS_SEC);
      min_q   <= (!in_setup && carry[0]) || (in_setup && press[2] && pos_q == POS_MIN);
      hour_q  <= (!in_setup && carry[1]) || (in_setup && press[2] && pos_q == POS_HOUR);
      asec_q  <= in_alarm && press[2] && pos_q == POS_SEC;
      amin_q  <= in_alarm && press[2] && pos_q == POS_MIN;
      ahour_q <= in_alarm && press[2] && pos_q == POS_HOUR;
      if (press[3]) alarm_en_q <= ~alarm_en_q;
    end
  end

  assign o_mode     = mode_q;
  assign o_position = pos_q;
  assign o_sec_clk  = sec_q;
  assign o_min_clk  = min_q;
  assign o_hour_clk = hour_q;

`ifdef CLKCTRL_ALARM_EN
  assign o_alarm_sec_clk  = asec_q;
  assign o_alarm_min_clk  = amin_q;
  assign o_alarm_hour_clk = ahour_q;
  assign o_alarm_en       = alarm_en_q;
`else
  logic unused_alarm;
  assign unused_alarm     = ^{i_sw_alarm, asec_q, amin_q, ahour_q, alarm_en_q};
  assign o_alarm_sec_clk  = 1'b0;
  assign o_alarm_min_clk  = 1'b0;
  assign o_alarm_hour_clk = 1'b0;
  assign o_alarm_en       = 1'b0;
`endif

endmodule

// File: tb/tb_clock_controller.sv
// Directed bench for clock_controller with CLK_HZ=20, DEB_CYCLES=4; alarm checks follow CLKCTRL_ALARM_EN.
module tb_clock_controller;

  localparam int CLK_HZ = 20;
  localparam int DEB    = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn = '0;
  logic       hit_sec = 1'b0, hit_min = 1'b0;
  logic [1:0] o_mode, o_position;
  logic       o_sec_clk, o_min_clk, o_hour_clk;
  logic       o_alarm_sec_clk, o_alarm_min_clk, o_alarm_hour_clk, o_alarm_en;

  clock_controller #(.CLK_HZ(CLK_HZ), .DEB_CYCLES(DEB)) dut (
    .clk              (clk),
    .rst              (rst),
    .i_sw_mode        (btn[0]),
    .i_sw_pos         (btn[1]),
    .i_sw_inc         (btn[2]),
    .i_sw_alarm       (btn[3]),
    .i_max_hit_sec    (hit_sec),
    .i_max_hit_min    (hit_min),
    .o_mode           (o_mode),
    .o_position       (o_position),
    .o_sec_clk        (o_sec_clk),
    .o_min_clk        (o_min_clk),
    .o_hour_clk       (o_hour_clk),
    .o_alarm_sec_clk  (o_alarm_sec_clk),
    .o_alarm_min_clk  (o_alarm_min_clk),
    .o_alarm_hour_clk (o_alarm_hour_clk),
    .o_alarm_en       (o_alarm_en)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int exp_mode = 0, exp_pos = 0;

  // Pulse counters and width monitor, sampled on the falling edge.
  int n_sec = 0, n_min = 0, n_hour = 0, n_asec = 0, n_amin = 0, n_ahour = 0, n_wide = 0;
  logic [5:0] prev_p = '0;
  always @(negedge clk) begin
    if (!rst) begin
      n_sec   += int'(o_sec_clk);
      n_min   += int'(o_min_clk);
      n_hour  += int'(o_hour_clk);
      n_asec  += int'(o_alarm_sec_clk);
      n_amin  += int'(o_alarm_min_clk);
      n_ahour += int'(o_alarm_hour_clk);
      if ((prev_p & {o_sec_clk, o_min_clk, o_hour_clk, o_alarm_sec_clk,
                     o_alarm_min_clk, o_alarm_hour_clk}) != '0) n_wide++;
      prev_p = {o_sec_clk, o_min_clk, o_hour_clk, o_alarm_sec_clk, o_alarm_min_clk, o_alarm_hour_clk};
    end else begin
      prev_p = '0;
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int nxt_mode(input int m);
`ifdef CLKCTRL_ALARM_EN
    return (m == 0) ? 1 : (m == 1) ? 2 : 0;
`else
    return (m == 0) ? 1 : 0;
`endif
  endfunction

  // Clean press: held 10 cycles, released for 12, so the event fully settles.
  task automatic push(input int b);
    btn[b] = 1'b1;
    cyc(10);
    btn[b] = 1'b0;
    cyc(12);
    if (b == 0) begin
      exp_mode = nxt_mode(exp_mode);
      exp_pos  = 0;
    end else if (b == 1) begin
      exp_pos = (exp_pos == 2) ? 0 : exp_pos + 1;
    end
  endtask

  task automatic goto_mode(input int target);
    for (int k = 0; k < 3; k++)
      if (exp_mode != target) push(0);
    chk("goto_mode", int'(o_mode), target);
  endtask

  int pulse_idx [$];
  int s_sec, s_min, s_hour, s_amin;

  initial begin
    // Reset values while rst is high.
    cyc(3);
    chk("rst_mode", int'(o_mode), 0);
    chk("rst_pos", int'(o_position), 0);
    chk("rst_sec_clk", int'(o_sec_clk), 0);
    chk("rst_alarm_en", int'(o_alarm_en), 0);
    @(negedge clk);
    rst = 1'b0;

    // 100 idle cycles: tick pulses after edges 20, 40, 60, 80, 100.
    for (int i = 1; i <= 100; i++) begin
      cyc(1);
      if (o_sec_clk) pulse_idx.push_back(i);
    end
    chk("idle_sec_count", pulse_idx.size(), 5);
    for (int k = 0; k < pulse_idx.size(); k++) chk("idle_sec_cycle", pulse_idx[k], 20 * (k + 1));
    chk("idle_mode", int'(o_mode), 0);
    chk("idle_pos", int'(o_position), 0);

    // Three mode presses, then position to HOUR and a mode press resets it.
    for (int k = 0; k < 3; k++) begin
      push(0);
      chk("mode_step", int'(o_mode), exp_mode);
    end
    push(1);
    push(1);
    chk("pos_hour", int'(o_position), 2);
    push(0);
    chk("pos_after_mode", int'(o_position), 0);
    chk("mode_after_pos", int'(o_mode), exp_mode);

    // SETUP: two position presses and an inc give one hour pulse; ticks masked.
    goto_mode(1);
    s_sec = n_sec; s_min = n_min; s_hour = n_hour;
    push(1);
    push(1);
    push(2);
    chk("setup_pos", int'(o_position), 2);
    chk("setup_hour_pulses", n_hour - s_hour, 1);
    chk("setup_min_pulses", n_min - s_min, 0);
    chk("setup_sec_masked", n_sec - s_sec, 0);

    // Bouncing mode button then steady high: exactly one step.
    for (int k = 0; k < 2; k++) begin
      btn[0] = 1'b1; cyc(2);
      btn[0] = 1'b0; cyc(2);
    end
    btn[0] = 1'b1; cyc(10);
    btn[0] = 1'b0; cyc(12);
    exp_mode = nxt_mode(exp_mode);
    exp_pos  = 0;
    chk("bounce_one_step", int'(o_mode), exp_mode);

    // Carry in CLOCK: min pulse exactly 3 cycles after the raw edge.
    goto_mode(0);
    s_min = n_min; s_hour = n_hour;
    hit_sec = 1'b1;
    cyc(2);
    chk("carry_min_c2", int'(o_min_clk), 0);
    cyc(1);
    chk("carry_min_c3", int'(o_min_clk), 1);
    cyc(1);
    chk("carry_min_c4", int'(o_min_clk), 0);
    hit_min = 1'b1;
    cyc(6);
    hit_sec = 1'b0; hit_min = 1'b0;
    cyc(6);
    chk("carry_min_count", n_min - s_min, 1);
    chk("carry_hour_count", n_hour - s_hour, 1);

    // Carry in SETUP is ignored.
    goto_mode(1);
    s_min = n_min;
    hit_sec = 1'b1;
    cyc(8);
    hit_sec = 1'b0;
    cyc(4);
    chk("setup_carry_ignored", n_min - s_min, 0);

`ifdef CLKCTRL_ALARM_EN
    // ALARM: inc at MIN pulses only the alarm minute clock; alarm presses toggle the enable.
    goto_mode(2);
    s_min = n_min; s_amin = n_amin;
    push(1);
    push(2);
    chk("alarm_pos", int'(o_position), 1);
    chk("alarm_min_pulse", n_amin - s_amin, 1);
    chk("alarm_time_min_quiet", n_min - s_min, 0);
    push(3);
    chk("alarm_en_on", int'(o_alarm_en), 1);
    push(3);
    chk("alarm_en_off", int'(o_alarm_en), 0);
    goto_mode(0);
`else
    // Without alarm support the alarm outputs stay low whatever is pressed.
    s_amin = n_amin + n_asec + n_ahour;
    push(3);
    chk("noalarm_en", int'(o_alarm_en), 0);
    push(2);
    chk("noalarm_clks", n_amin + n_asec + n_ahour - s_amin, 0);
    goto_mode(0);
`endif

    // Reset mid-debounce discards the partial press.
    btn[0] = 1'b1;
    cyc(4);
    rst = 1'b1;
    btn[0] = 1'b0;
    cyc(3);
    @(negedge clk);
    rst = 1'b0;
    exp_mode = 0; exp_pos = 0;
    cyc(20);
    chk("rst_mid_debounce", int'(o_mode), 0);

    // Button held through reset release: mode steps once, visible after edge DEB+3.
    btn[0] = 1'b1;
    rst = 1'b1;
    cyc(3);
    @(negedge clk);
    rst = 1'b0;
    cyc(DEB + 1);
    chk("held_rst_early", int'(o_mode), 0);
    cyc(2);
    chk("held_rst_step", int'(o_mode), 1);
    cyc(30);
    chk("held_rst_once", int'(o_mode), 1);
    btn[0] = 1'b0;
    cyc(12);

    chk("pulse_width", n_wide, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/clock_controller.md
CLOCK_CONTROLLER -- requirements
Module: clock_controller

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000: clk cycles per 1 Hz time tick.
REQ-002 SHALL have parameter DEB_CYCLES, default 500000: cycles a button input must hold stable before its debounced level changes.
REQ-003 SHALL have ports: clk  in  1  system clock, all logic on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 i_sw_mode, i_sw_pos, i_sw_inc, i_sw_alarm  in  1 each  raw push buttons, high = pressed.
REQ-006 i_max_hit_sec, i_max_hit_min  in  1 each  carry levels from the sec and min counters.
REQ-007 o_mode  out  2  0 = CLOCK, 1 = SETUP, 2 = ALARM.
REQ-008 o_position  out  2  0 = SEC, 1 = MIN, 2 = HOUR.
REQ-009 o_sec_clk, o_min_clk, o_hour_clk  out  1 each  time-counter advance pulses.
REQ-010 o_alarm_sec_clk, o_alarm_min_clk, o_alarm_hour_clk  out  1 each  alarm-counter advance pulses.
REQ-011 o_alarm_en  out  1  alarm enable level.

Function
REQ-012 Each button and each i_max_hit_* SHALL pass through a 2-FF synchronizer.
REQ-013 Each debounced level SHALL take the synchronized value only after DEB_CYCLES consecutive identical samples; any change SHALL restart the count.
REQ-014 A press SHALL be the 0->1 edge of a debounced level, giving exactly one press event per physical press.
REQ-015 The tick counter SHALL count 0..CLK_HZ-1, wrap to 0, run in all modes, and assert tick for one cycle at CLK_HZ-1.
REQ-016 Mode FSM SHALL step CLOCK->SETUP->ALARM->CLOCK on each mode press; code 3 is unreachable and SHALL decode as CLOCK.
REQ-017 Each position press SHALL step position SEC->MIN->HOUR->SEC; any mode change SHALL force position to SEC.
REQ-018 If a mode press and a position press occur in the same cycle, the mode step SHALL win and position SHALL become SEC.
REQ-019 o_sec_clk SHALL pulse on tick in CLOCK and ALARM; ticks SHALL be masked in SETUP.
REQ-020 On a rising edge of synchronized i_max_hit_sec, o_min_clk SHALL pulse in CLOCK and ALARM; on a rising edge of i_max_hit_min, o_hour_clk SHALL pulse in those modes; carries SHALL be ignored in SETUP.
REQ-021 An inc press in SETUP SHALL pulse the time clk selected by position; in ALARM it SHALL pulse the selected alarm clk; in CLOCK it SHALL have no effect.
REQ-022 An alarm press SHALL toggle o_alarm_en in any mode.
REQ-023 All outputs SHALL be registered, and every o_*clk pulse SHALL be exactly one clk cycle wide, asserted the cycle after its causing event (tick, synchronized carry edge, or debounced edge).
REQ-024 Coincident sources for the same output in one cycle SHALL produce a single pulse.

Reset
REQ-025 While rst is high, the block SHALL force o_mode = CLOCK, o_position = SEC, all o_*clk = 0, o_alarm_en = 0, and all counters, synchronizers and debounced levels to 0.
REQ-026 Assertion of rst SHALL discard any partially debounced press.
REQ-027 A button held through reset release SHALL register as one press DEB_CYCLES+2 cycles after release.

Configuration
REQ-028 With macro CLKCTRL_ALARM_EN defined, the ALARM mode, alarm clocks and o_alarm_en SHALL behave as specified above.
REQ-029 Without CLKCTRL_ALARM_EN, the mode FSM SHALL cycle CLOCK<->SETUP only, o_alarm_*clk and o_alarm_en SHALL be tied 0, and i_sw_alarm SHALL be ignored.

Verification (CLK_HZ=20, DEB_CYCLES=4, CLKCTRL_ALARM_EN defined)
REQ-030 Reset, then run 100 cycles idle -> o_mode=0, o_position=0, o_sec_clk pulses exactly 5 times, each 1 cycle wide, 20 cycles apart.
REQ-031 Three clean mode presses -> o_mode 0->1->2->0; a mode press with o_position=2 -> o_position=0.
REQ-032 Mode press, two position presses, one inc press -> exactly one o_hour_clk pulse; o_sec_clk stays 0 throughout SETUP.
REQ-033 Mode press bouncing 1,0,1,0 every 2 cycles, then steady high for 10 cycles -> exactly one mode step.
REQ-034 In CLOCK, drive i_max_hit_sec 0->1 -> one o_min_clk pulse 3 cycles later; repeat in SETUP -> no pulse.
REQ-035 In ALARM, inc press at position MIN -> one o_alarm_min_clk pulse; two alarm presses -> o_alarm_en 0->1->0; assert rst mid-debounce -> no event after release.
